// File: rtl/ram_bridge_pkg.sv
// Shared encodings for the word-to-byte RAM bridge.
// Holds FSM states, byte-count limits and the latched request layout.
package ram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [2:0] RD_LAST_CNT    = 3'd4;
    localparam logic [2:0] WR_LAST_CNT    = 3'd3;

    typedef struct packed {
        logic [8*BYTES_PER_WORD-1:0] dat;
        logic [BYTES_PER_WORD-1:0]   sel;
    } wb_req_t;

    function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] i);
        return w[8*i +: 8];
    endfunction

endpackage

// File: rtl/ff_ram.sv
// Byte-wide RAM with separate write and read ports.
// Read data is registered: one cycle from o_raddr to i_rdata; no backpressure.
module ff_ram #(
    parameter int aw      = 10,
    parameter int memsize = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    i_wdata,
    input  logic [aw-1:0] i_waddr,
    input  logic          i_wen,
    input  logic [aw-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] mem [0:memsize-1];

    always_ff @(posedge clk) begin
        if (i_wen)
            mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            o_rdata <= 8'h00;
        else
            o_rdata <= mem[i_raddr];
    end

endmodule

// File: rtl/ram_word_bridge.sv
// 32-bit Wishbone-style word access split into four byte accesses on ff_ram.
// Ack 5 cycles after request for writes, 6 for reads; one request in flight, cyc held until ack.
module ram_word_bridge
    import ram_bridge_pkg::*;
#(
    parameter int aw = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [aw-3:0] i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_cyc,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic          o_wen,
    output logic [aw-1:0] o_waddr,
    output logic [7:0]    o_wdata,
    output logic [aw-1:0] o_raddr,
    input  logic [7:0]    i_rdata
);

    state_t        state;
    logic [2:0]    cnt;
    logic [2:0]    cnt_nxt;
    logic [1:0]    rd_lane;
    logic [aw-3:0] adr_q;
    wb_req_t       req_q;

    assign cnt_nxt = cnt + 3'd1;
    // RAM data arriving at count c belongs to the address issued at count c-1
    assign rd_lane = cnt[1:0] - 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            adr_q    <= '0;
            req_q    <= '0;
            o_wb_ack <= 1'b0;
            o_wen    <= 1'b0;
            o_wb_rdt <= 32'h0;
            o_waddr  <= '0;
            o_raddr  <= '0;
            o_wdata  <= 8'h00;
        end else begin
            o_wb_ack <= 1'b0;
            o_wen    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_wb_cyc) begin
                        adr_q     <= i_wb_adr;
                        req_q.dat <= i_wb_dat;
                        req_q.sel <= i_wb_sel;
                        cnt       <= 3'd0;
                        // Outputs are registered, so byte 0 is set up while latching
                        o_waddr   <= {i_wb_adr, 2'b00};
                        o_wdata   <= i_wb_dat[7:0];
                        o_raddr   <= {i_wb_adr, 2'b00};
                        if (i_wb_we) begin
                            o_wen <= i_wb_sel[0];
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                WRITE: begin
                    cnt <= cnt_nxt;
                    if (cnt == WR_LAST_CNT) begin
                        state    <= ACK;
                        o_wb_ack <= 1'b1;
                    end else begin
                        o_waddr <= {adr_q, cnt_nxt[1:0]};
                        o_wdata <= lane(req_q.dat, cnt_nxt[1:0]);
                        o_wen   <= req_q.sel[cnt_nxt[1:0]];
                    end
                end
                READ: begin
                    cnt <= cnt_nxt;
                    if (cnt != 3'd0)
                        o_wb_rdt[8*rd_lane +: 8] <= i_rdata;
                    if (cnt == RD_LAST_CNT) begin
                        state    <= ACK;
                        o_wb_ack <= 1'b1;
                        o_raddr  <= {adr_q, 2'b00};
                    end else begin
                        o_raddr <= {adr_q, cnt_nxt[1:0]};
                    end
                end
                ACK: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_word_bridge.sv
// Bench for ram_word_bridge driving a real ff_ram; expected byte writes and acks
// are queued at issue time and checked by independent monitors.
module tb_ram_word_bridge;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-3:0] i_wb_adr;
    logic [31:0]   i_wb_dat;
    logic [3:0]    i_wb_sel;
    logic          i_wb_we;
    logic          i_wb_cyc;
    logic [31:0]   o_wb_rdt;
    logic          o_wb_ack;
    logic          o_wen;
    logic [AW-1:0] o_waddr;
    logic [7:0]    o_wdata;
    logic [AW-1:0] o_raddr;
    logic [7:0]    i_rdata;

    always #5 clk = ~clk;

    ram_word_bridge #(.aw(AW)) dut (
        .clk(clk), .reset(reset),
        .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc),
        .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
        .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata),
        .o_raddr(o_raddr), .i_rdata(i_rdata)
    );

    ff_ram #(.aw(AW), .memsize(1024)) ram (
        .clk(clk), .reset(reset),
        .i_wdata(o_wdata), .i_waddr(o_waddr), .i_wen(o_wen),
        .i_raddr(o_raddr), .o_rdata(i_rdata)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdt;
        logic        rd;
    } ack_exp_t;

    wr_exp_t  wr_q[$];
    ack_exp_t ack_q[$];
    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Byte-write monitor
    always @(negedge clk) begin
        wr_exp_t e;
        if (o_wen === 1'b1) begin
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL wen_unexpected cyc=%0d addr=%h data=%h, want no write", cyc_cnt, o_waddr, o_wdata);
            end else begin
                e = wr_q.pop_front();
                if (o_waddr !== e.addr || o_wdata !== e.data || cyc_cnt != e.cyc) begin
                    bad++;
                    $display("FAIL byte_write got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                             o_waddr, o_wdata, cyc_cnt, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    // Ack monitor
    always @(negedge clk) begin
        ack_exp_t a;
        if (o_wb_ack === 1'b1) begin
            total++;
            if (ack_q.size() == 0) begin
                bad++;
                $display("FAIL ack_unexpected cyc=%0d rdt=%h, want no ack", cyc_cnt, o_wb_rdt);
            end else begin
                a = ack_q.pop_front();
                if (cyc_cnt != a.cyc || (a.rd && o_wb_rdt !== a.rdt)) begin
                    bad++;
                    $display("FAIL ack_resp got cyc=%0d rdt=%h want cyc=%0d rdt=%h (read=%0b)",
                             cyc_cnt, o_wb_rdt, a.cyc, a.rdt, a.rd);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Write latency 5 cycles, read 6, counting the cycle after the sampling edge as 1
    task automatic txn(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp_rdt, input logic hold);
        int c0;
        bit seen;
        logic [1:0] li;
        @(negedge clk);
        i_wb_cyc = 1'b1;
        i_wb_we  = we;
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = sel;
        c0 = cyc_cnt + 1;
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                li = 2'(i);
                if (sel[i])
                    wr_q.push_back('{c0 + i, {adr, li}, dat[8*i +: 8]});
            end
        end
        ack_q.push_back('{we ? c0 + 4 : c0 + 5, exp_rdt, !we});
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (o_wb_ack === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ack_timeout adr=%h got no ack want ack", adr);
        end
        if (!hold) i_wb_cyc = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},   {31'b0, o_wb_ack}, 32'h0);
        chk({tag, "_wen"},   {31'b0, o_wen},    32'h0);
        chk({tag, "_rdt"},   o_wb_rdt,          32'h0);
        chk({tag, "_waddr"}, 32'(o_waddr),      32'h0);
        chk({tag, "_raddr"}, 32'(o_raddr),      32'h0);
        chk({tag, "_wdata"}, 32'(o_wdata),      32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got hang want completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        i_wb_adr = '0;
        i_wb_dat = 32'h0;
        i_wb_sel = 4'h0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Word 0 seeded so later aliasing from the top word would show
        txn(1'b1, 8'h00, 32'h0123_4567, 4'hF, 32'h0, 1'b0);

        txn(1'b1, 8'h05, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        txn(1'b0, 8'h05, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        txn(1'b1, 8'h05, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        txn(1'b0, 8'h05, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

        txn(1'b1, 8'h05, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
        txn(1'b0, 8'h05, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

        txn(1'b1, 8'hFF, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0);
        txn(1'b0, 8'hFF, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0);
        txn(1'b0, 8'h00, 32'h0, 4'h0, 32'h0123_4567, 1'b0);

        // cyc held across the boundary between the two transactions
        txn(1'b1, 8'h01, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1);
        txn(1'b0, 8'h01, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

        // Reset while the read is at cnt=2: no ack may follow
        @(negedge clk);
        i_wb_cyc = 1'b1;
        i_wb_we  = 1'b0;
        i_wb_adr = 8'h05;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b1;
        i_wb_cyc = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midread");
        reset = 1'b0;
        repeat (8) @(negedge clk);

        txn(1'b0, 8'h05, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);
        txn(1'b1, 8'h02, 32'h8765_4321, 4'b1010, 32'h0, 1'b0);
        repeat (3) @(negedge clk);

        chk("wr_queue_drained",  32'(wr_q.size()),  32'h0);
        chk("ack_queue_drained", 32'(ack_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
